// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM encoding and
// byte-lane constants for little-endian word assembly.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    localparam logic [LANE_W-1:0] LANE_FIRST = '0;
    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/word_assembler.sv
// Collects bytes into little-endian 32-bit words; word_vld_o pulses
// combinationally with the byte that completes a word.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              byte_vld_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_vld_o,
    output logic [WORD_W-1:0] word_o
);

    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;

    // Earlier bytes shift down, so the first byte lands in [7:0] once the
    // fourth byte is placed on top.
    assign word_vld_o = byte_vld_i && (lane_q == LANE_LAST);
    assign word_o     = {byte_i, shift_q};

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clr_i) begin
            lane_d  = LANE_FIRST;
            shift_d = '0;
        end else if (byte_vld_i) begin
            lane_d  = lane_q + 1'b1;
            shift_d = {byte_i, shift_q[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= LANE_FIRST;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: reads a word count then that many little-endian words from a
// byte stream and writes them to instruction RAM, holding the core meanwhile.
module inst_loader
    import loader_pkg::*;
#(
    parameter int           W         = 32,
    parameter logic [W-1:0] BASE_ADDR = '0,
    parameter int           MAX_WORDS = 2048,
    parameter int           TIMEOUT   = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         is_write,
    output logic [W-1:0] im_addr,
    output logic [W-1:0] im_inst,
    output logic         core_hold,
    output logic         load_done,
    output logic         load_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_e            state_q, state_d;
    logic [W-1:0]      n_q, n_d, k_q, k_d, addr_q, addr_d, inst_q, inst_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic              wr_q, wr_d;
    logic              acc, asm_clr, word_vld, timed_out;
    logic [WORD_W-1:0] word;

    assign rx_ready  = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign acc       = rx_valid && rx_ready;
    assign timed_out = (TIMEOUT != 0) && !acc && (idle_q == TO_LAST);

    assign is_write  = wr_q;
    assign im_addr   = addr_q;
    assign im_inst   = inst_q;
    assign core_hold = rx_ready || (state_q == ST_ERR);
    assign load_done = (state_q == ST_DONE);
    assign load_err  = (state_q == ST_ERR);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (asm_clr),
        .byte_vld_i (acc),
        .byte_i     (rx_data),
        .word_vld_o (word_vld),
        .word_o     (word)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        idle_d  = idle_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        inst_d  = inst_q;
        asm_clr = 1'b0;

        // Idle counter only runs while bytes are expected; saturates at all-ones.
        if (!rx_ready || acc)   idle_d = '0;
        else if (idle_q != '1)  idle_d = idle_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN;
                    asm_clr = 1'b1;
                    k_d     = '0;
                end
            end
            ST_LEN: begin
                if (word_vld) begin
                    n_d = W'(word);
                    if (word == '0)                          state_d = ST_DONE;
                    else if (word > WORD_W'(MAX_WORDS))      state_d = ST_ERR;
                    else                                     state_d = ST_DATA;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA: begin
                if (word_vld) begin
                    wr_d   = 1'b1;
                    inst_d = W'(word);
                    addr_d = BASE_ADDR + (k_q << 2);
                    k_d    = k_q + 1'b1;
                end
                // Leave on the write cycle of the last word so load_done follows it.
                if (wr_q && (k_q == n_q))  state_d = ST_DONE;
                else if (timed_out)        state_d = ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            idle_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            idle_q  <= idle_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: a queue of expected RAM writes derived from
// the image is checked against every is_write, plus session-level outcomes.
module tb_inst_loader;

    localparam int          MAXW = 16;
    localparam int          TOUT = 16;
    localparam logic [31:0] BASE = 32'h0;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, is_write, core_hold, load_done, load_err;
    logic [31:0] im_addr, im_inst;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    wq_t exp_a, exp_d, log_a, log_d;
    bit   chk_static = 1'b0;
    logic exp_hold = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic [31:0] ca, cd;

    inst_loader #(.W(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .is_write(is_write), .im_addr(im_addr), .im_inst(im_inst),
        .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Every write must match the head of the expected queue; outside sessions
    // the loader must refuse bytes and show a steady status.
    always @(negedge clk) begin
        if (rst_n) begin
            if (is_write) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h inst=%h", im_addr, im_inst);
                end else begin
                    ca = exp_a.pop_front();
                    cd = exp_d.pop_front();
                    if (im_addr !== ca || im_inst !== cd) begin
                        errors++;
                        $display("FAIL write got=%h@%h exp=%h@%h", im_inst, im_addr, cd, ca);
                    end
                end
                log_a.push_back(im_addr);
                log_d.push_back(im_inst);
            end
            if (chk_static) begin
                checks++;
                if (rx_ready !== 1'b0 || is_write !== 1'b0 || core_hold !== exp_hold ||
                    load_done !== exp_done || load_err !== exp_err) begin
                    errors++;
                    $display("FAIL static rdy=%b wr=%b hold=%b done=%b err=%b exp hold=%b done=%b err=%b",
                             rx_ready, is_write, core_hold, load_done, load_err, exp_hold, exp_done, exp_err);
                end
            end
        end
    end

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap, input bit spur);
        bit ok = 1'b0;
        int g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        if (spur && $urandom_range(2, 0) == 0) start = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            ok = rx_ready;
            @(negedge clk);
            start = 1'b0;
        end
        rx_valid = 1'b0;
        last_acc = cyc;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept got=0 exp=1 byte=%h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap, input bit spur);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], maxgap, spur);
    endtask

    task automatic idle_window(input logic hold, input logic done, input logic err);
        exp_hold = hold; exp_done = done; exp_err = err;
        chk_static = 1'b1;
        repeat (6) begin
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk_static = 1'b0;
    endtask

    task automatic run_image(input logic [31:0] n, input wq_t img, input int maxgap, input bit spur);
        bit ok_len = (n != 0) && (n <= MAXW);
        log_a.delete(); log_d.delete();
        if (ok_len)
            for (int k = 0; k < img.size(); k++) begin
                exp_a.push_back(BASE + 32'(4 * k));
                exp_d.push_back(img[k]);
            end
        start_pulse();
        send_word(n, maxgap, 1'b0);
        if (ok_len) foreach (img[k]) send_word(img[k], maxgap, spur);
        for (int i = 0; i < 30 && !(load_done || load_err); i++) @(negedge clk);
        chk("end_done", {31'b0, load_done}, {31'b0, n <= MAXW});
        chk("end_err",  {31'b0, load_err},  {31'b0, n > MAXW});
        chk("end_hold", {31'b0, core_hold}, {31'b0, n > MAXW});
        chk("pending_writes", exp_a.size(), 0);
        idle_window(n > MAXW, n <= MAXW, n > MAXW);
    endtask

    function automatic wq_t rand_img(input int n);
        wq_t q;
        for (int i = 0; i < n; i++) q.push_back($urandom);
        return q;
    endfunction

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_rdy"},  {31'b0, rx_ready},  0);
        chk({nm, "_wr"},   {31'b0, is_write},  0);
        chk({nm, "_hold"}, {31'b0, core_hold}, 0);
        chk({nm, "_done"}, {31'b0, load_done}, 0);
        chk({nm, "_err"},  {31'b0, load_err},  0);
        chk({nm, "_addr"}, im_addr, BASE);
        chk({nm, "_inst"}, im_inst, 0);
    endtask

    initial begin
        wq_t img, ref_a, ref_d;
        int  t_err;

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        idle_window(1'b0, 1'b0, 1'b0);

        // Known two-word program; literal expectations pin the model.
        img = '{32'h00000013, 32'h00100093};
        run_image(32'd2, img, 0, 1'b0);
        chk("t1_nwr", log_d.size(), 2);
        if (log_d.size() == 2) begin
            chk("t1_d0", log_d[0], 32'h00000013);
            chk("t1_a0", log_a[0], 32'h0);
            chk("t1_d1", log_d[1], 32'h00100093);
            chk("t1_a1", log_a[1], 32'h4);
        end

        run_image(32'd0, img, 0, 1'b0);
        chk("t2_nwr", log_d.size(), 0);

        run_image(32'(MAXW + 1), img, 0, 1'b0);
        chk("t3_nwr", log_d.size(), 0);
        run_image(32'd5, rand_img(5), 0, 1'b0);
        run_image(32'(MAXW), rand_img(MAXW), 0, 1'b0);
        chk("max_nwr", log_d.size(), MAXW);

        // Gappy stream must give the same writes as a gap-free one.
        img = rand_img(6);
        run_image(32'd6, img, 0, 1'b0);
        ref_a = log_a; ref_d = log_d;
        run_image(32'd6, img, 10, 1'b0);
        chk("gap_nwr", log_d.size(), ref_d.size());
        foreach (ref_d[i]) if (i < log_d.size()) begin
            chk("gap_d", log_d[i], ref_d[i]);
            chk("gap_a", log_a[i], ref_a[i]);
        end

        // Stall mid-word: error exactly TOUT cycles after the last accepted byte.
        img = rand_img(1);
        exp_a.push_back(BASE); exp_d.push_back(img[0]);
        start_pulse();
        send_word(32'd4, 3, 1'b0);
        send_word(img[0], 3, 1'b0);
        send_byte(8'hAA, 3, 1'b0);
        send_byte(8'h55, 3, 1'b0);
        t_err = -1;
        for (int i = 0; i < 40 && t_err < 0; i++) begin
            if (load_err) t_err = cyc - last_acc;
            else @(negedge clk);
        end
        chk("timeout_cycles", t_err, TOUT);
        chk("timeout_hold", {31'b0, core_hold}, 1);
        chk("timeout_pending", exp_a.size(), 0);
        idle_window(1'b1, 1'b0, 1'b1);

        // Asynchronous reset after 3 of 5 words.
        img = rand_img(5);
        for (int k = 0; k < 3; k++) begin
            exp_a.push_back(BASE + 32'(4 * k)); exp_d.push_back(img[k]);
        end
        start_pulse();
        send_word(32'd5, 0, 1'b0);
        for (int k = 0; k < 3; k++) send_word(img[k], 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_prewrites", exp_a.size(), 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_image(32'd5, rand_img(5), 0, 1'b0);
        if (log_a.size() > 0) chk("reload_a0", log_a[0], BASE);

        // Back-to-back bytes with stray start pulses during DATA.
        run_image(32'd8, rand_img(8), 0, 1'b1);
        chk("b2b_nwr", log_d.size(), 8);
        foreach (log_a[i]) chk("b2b_addr", log_a[i], BASE + 32'(4 * i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
